// File: rtl/mem_copy_engine.sv
// Byte-at-a-time block copy engine for the single-port 8-bit data memory.
// Optional running checksum of copied bytes: define MEM_COPY_CHECKSUM_EN.
module mem_copy_engine (
    input  logic       CLK,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] src_addr,
    input  logic [7:0] dst_addr,
    input  logic [7:0] length,
    output logic [7:0] Data_address,
    output logic       Data_read_en,
    output logic       Data_write_en,
    output logic [7:0] Data_memory_in,
    input  logic [7:0] Data_memory_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state, state_next;
    logic [7:0] src_q, dst_q, rem_q, data_q;
    logic       accept;

    assign accept = (state == IDLE) && start;

    always_ff @(posedge CLK) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (length == '0) ? DONE : READ;
            READ:    state_next = WRITE;
            WRITE:   state_next = (rem_q == 8'd1) ? DONE : READ;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Data_address   = '0;
        Data_read_en   = 1'b0;
        Data_write_en  = 1'b0;
        Data_memory_in = '0;
        case (state)
            READ: begin
                Data_address = src_q;
                Data_read_en = 1'b1;
            end
            WRITE: begin
                Data_address   = dst_q;
                Data_write_en  = 1'b1;
                Data_memory_in = data_q;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Address registers wrap naturally at 8 bits.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            src_q  <= '0;
            dst_q  <= '0;
            rem_q  <= '0;
            data_q <= '0;
        end else begin
            if (accept) begin
                src_q <= src_addr;
                dst_q <= dst_addr;
                rem_q <= length;
            end
            if (state == READ) data_q <= Data_memory_out;
            if (state == WRITE) begin
                src_q <= src_q + 8'd1;
                dst_q <= dst_q + 8'd1;
                rem_q <= rem_q - 8'd1;
            end
        end
    end

`ifdef MEM_COPY_CHECKSUM_EN
    logic [7:0] checksum_q;

    always_ff @(posedge CLK) begin
        if (!reset)              checksum_q <= '0;
        else if (accept)         checksum_q <= '0;
        else if (state == WRITE) checksum_q <= checksum_q + data_q;
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: reference memory model predicts every
// read address and write, the monitor pops and compares as the DUT drives the bus.
module tb_mem_copy_engine;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] src_addr = '0, dst_addr = '0, length = '0;
    logic [7:0] Data_address, Data_memory_in, Data_memory_out, checksum;
    logic       Data_read_en, Data_write_en, busy, done;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];
    logic [15:0] wr_q [$];
    logic [7:0]  rd_q [$];
    logic        mon_en = 1'b0;
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = '0, pl_data = '0;

    mem_copy_engine dut (
        .CLK             (CLK),
        .reset           (reset),
        .start           (start),
        .src_addr        (src_addr),
        .dst_addr        (dst_addr),
        .length          (length),
        .Data_address    (Data_address),
        .Data_read_en    (Data_read_en),
        .Data_write_en   (Data_write_en),
        .Data_memory_in  (Data_memory_in),
        .Data_memory_out (Data_memory_out),
        .busy            (busy),
        .done            (done),
        .checksum        (checksum)
    );

    always #5 CLK = ~CLK;

    assign Data_memory_out = Data_read_en ? mem[Data_address] : 8'h00;

    always @(posedge CLK) begin
        if (Data_write_en) mem[Data_address] <= Data_memory_in;
        else if (pl_en)    mem[pl_addr] <= pl_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            check("rd_wr_excl", 32'(Data_read_en & Data_write_en), 32'd0);
            if (!busy)
                check("bus_idle", {13'd0, Data_address, Data_read_en, Data_write_en, Data_memory_in}, 32'd0);
            if (Data_write_en) begin
                if (wr_q.size() == 0) check("wr_extra", 32'(Data_write_en), 32'd0);
                else begin
                    logic [15:0] w;
                    w = wr_q.pop_front();
                    check("wr_addr", 32'(Data_address), 32'(w[15:8]));
                    check("wr_data", 32'(Data_memory_in), 32'(w[7:0]));
                end
            end
            if (Data_read_en) begin
                if (rd_q.size() == 0) check("rd_extra", 32'(Data_read_en), 32'd0);
                else begin
                    logic [7:0] a;
                    a = rd_q.pop_front();
                    check("rd_addr", 32'(Data_address), 32'(a));
                end
            end
        end
    end

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge CLK);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        ref_mem[a] = d;
        @(negedge CLK);
        pl_en = 1'b0;
    endtask

    task automatic check_mem_image();
        int bad = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== ref_mem[i]) bad++;
        check("mem_image", 32'(bad), 32'd0);
    endtask

    // glitch_at: cycle in which a second start pulse (different src) is driven.
    // rst_at: cycle in which reset is driven low (0 = no reset).
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                            input int glitch_at, input int rst_at);
        int         last;
        logic [7:0] sum, data;
        last = 2 * int'(l) + 1;
        sum  = '0;
        for (int k = 0; k < int'(l); k++) begin
            if (rst_at == 0 || 2 * k + 1 <= rst_at) rd_q.push_back(8'(int'(s) + k));
            if (rst_at == 0 || 2 * k + 2 <= rst_at) begin
                data = ref_mem[8'(int'(s) + k)];
                ref_mem[8'(int'(d) + k)] = data;
                wr_q.push_back({8'(int'(d) + k), data});
                sum = sum + data;
            end
        end
        @(negedge CLK);
        src_addr = s; dst_addr = d; length = l; start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0; src_addr = ~s; dst_addr = ~d; length = 8'(int'(l) + 7);
        for (int c = 1; c <= last + 1; c++) begin
            @(negedge CLK);
            if (rst_at != 0 && c > rst_at) begin
                reset = 1'b1;
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_bus", {13'd0, Data_address, Data_read_en, Data_write_en, Data_memory_in}, 32'd0);
                check("rst_cksum", 32'(checksum), 32'd0);
                for (int j = 0; j < 6; j++) begin
                    @(negedge CLK);
                    check("rst_no_done", 32'(done), 32'd0);
                end
                break;
            end
            check("busy", 32'(busy), 32'(c <= last));
            check("done", 32'(done), 32'(c == last));
            if (c == glitch_at) begin
                start = 1'b1;
                src_addr = s + 8'd50;
            end else begin
                start = 1'b0;
            end
            if (c == rst_at) reset = 1'b0;
        end
        start = 1'b0;
        check("wr_pending", 32'(wr_q.size()), 32'd0);
        check("rd_pending", 32'(rd_q.size()), 32'd0);
        if (rst_at == 0) begin
`ifdef MEM_COPY_CHECKSUM_EN
            check("checksum", 32'(checksum), 32'(sum));
`else
            check("checksum", 32'(checksum), 32'd0);
`endif
        end
        check_mem_image();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom_range(0, 255)));
        @(negedge CLK);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bus", {13'd0, Data_address, Data_read_en, Data_write_en, Data_memory_in}, 32'd0);
        check("reset_cksum", 32'(checksum), 32'd0);
        mon_en = 1'b1;

        preload(8'd16, 8'd254); preload(8'd17, 8'd7); preload(8'd18, 8'd9);
        run_copy(8'd16, 8'd100, 8'd3, 0, 0);
        check("basic_m100", 32'(mem[100]), 32'd254);
        check("basic_m102", 32'(mem[102]), 32'd9);

        run_copy(8'd5, 8'd6, 8'd0, 0, 0);

        preload(8'd254, 8'd1); preload(8'd255, 8'd2); preload(8'd0, 8'd3);
        run_copy(8'd254, 8'd250, 8'd3, 0, 0);
        check("wrap_m252", 32'(mem[252]), 32'd3);

        run_copy(8'd40, 8'd60, 8'd4, 3, 0);

        run_copy(8'd80, 8'd120, 8'd5, 0, 4);
        run_copy(8'd80, 8'd120, 8'd5, 0, 0);

        run_copy(8'd10, 8'd11, 8'd5, 0, 0);

        for (int n = 0; n < 50; n++)
            run_copy(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 20)), 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Block-copy initiator for the single-port 8-bit data memory. Given a source address, a destination address and a byte count, it moves bytes one at a time through the memory's shared address pointer: a combinational read cycle, then a write cycle. It sits beside the core on the data-memory bus and presents a start/busy/done handshake to the controller. The core must not drive the memory while `busy` is high.

## Interface
- No parameters; address and data widths are fixed at 8 bits.
- `CLK` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low; 0 at a rising edge resets the block.
- `start` in 1: request a copy; sampled only in IDLE.
- `src_addr` in 8: first source byte address; latched on accepted start.
- `dst_addr` in 8: first destination byte address; latched on accepted start.
- `length` in 8: number of bytes to copy, 0..255; latched on accepted start.
- `Data_address` out 8: shared memory address pointer.
- `Data_read_en` out 1: memory read enable.
- `Data_write_en` out 1: memory write enable.
- `Data_memory_in` out 8: write data to memory.
- `Data_memory_out` in 8: combinational read data from memory; valid only while `Data_read_en` is 1.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a copy completes.
- `checksum` out 8: running sum of copied bytes (see Configuration).

## Operation
- States: IDLE, READ, WRITE, DONE.
- **IDLE**
  - If `start`=1 at the edge, latch `src_addr`, `dst_addr` and `length`.
  - Go to READ if length≠0; go to DONE if length=0.
- **READ**
  - Drive `Data_address`=src, `Data_read_en`=1.
  - At the edge, capture `Data_memory_out` into the data register and go to WRITE.
- **WRITE**
  - Drive `Data_address`=dst, `Data_write_en`=1, `Data_memory_in`=data register.
  - At the edge: src+=1, dst+=1, remaining-=1.
  - Go to DONE if remaining becomes 0; otherwise go to READ.
- **DONE**
  - `done`=1 for this cycle.
  - Next state is IDLE unconditionally. `start` is ignored here.
- Address arithmetic is modulo 256: 255+1 wraps to 0 for both src and dst.
- Copy order is always ascending. Overlapping regions with dst>src in (src, src+length) propagate already-copied bytes; this behaviour is defined, not an error.
- `start` is ignored while `busy`=1. Input changes after the start edge have no effect on the copy in progress.
- Bus idle values, in IDLE and DONE: `Data_address`=0, `Data_read_en`=0, `Data_write_en`=0, `Data_memory_in`=0.
- `Data_read_en` and `Data_write_en` are never high in the same cycle.

## Timing
- Reset values: state IDLE; all bus outputs 0; `busy`=0; `done`=0; `checksum`=0; internal src, dst, remaining and data registers 0.
- Reset mid-copy: at the reset edge the block returns to IDLE. No further write is issued and no `done` pulse occurs. Bytes already written stay written.
- Let E0 be the edge at which `start` is accepted, with L = length.
  - Byte k (0-based) is read in cycle 2k+1 after E0 and written in cycle 2k+2.
  - `done` is high in cycle 2L+1.
  - `busy` is high in cycles 1 through 2L+1.
- L=0: `done` is high in cycle 1 and no memory access occurs.
- Earliest back-to-back start: `start` held high is accepted at the edge ending cycle 2L+2.
- Throughput is 2 cycles per byte.

## Configuration
- Macro `MEM_COPY_CHECKSUM_EN`.
- **Defined:**
  - `checksum` is cleared to 0 on accepted start.
  - At each WRITE edge, `checksum` += data register, modulo 256.
  - `checksum` holds its value after DONE until the next accepted start or reset.
- **Undefined:**
  - No accumulator is built.
  - `checksum` is tied to 0.
  - All other behaviour and timing are identical.

## Test plan
- **Basic copy.** Preload M[16]=254, M[17]=7, M[18]=9. Start with src=16, dst=100, length=3.
  - Required: M[100..102]=254,7,9.
  - `done` in cycle 7; `busy` high in cycles 1–7.
  - Checksum (if enabled) = 14, i.e. 270 mod 256.
- **Zero length.** Start with length=0.
  - `done` in cycle 1.
  - `Data_read_en` and `Data_write_en` never assert.
  - Memory is unchanged.
- **Wrap-around.** Preload M[254]=1, M[255]=2, M[0]=3. Start with src=254, dst=250, length=3.
  - Required: M[250..252]=1,2,3.
  - Read addresses observed: 254, 255, 0.
- **Start while busy.** Pulse `start` again, with different src, in cycle 3 of a 4-byte copy.
  - The second request is ignored; only the original 4 bytes are copied.
  - `done` pulses once, in cycle 9.
- **Reset mid-copy.** Drive `reset`=0 in cycle 4 of a 5-byte copy.
  - Only bytes 0 and 1 are written.
  - The block is in IDLE with all outputs 0.
  - No `done` pulse occurs; the next start works normally.
- **Bus exclusivity.** Random copies of 50 lengths, checked with assertions.
  - `Data_read_en` & `Data_write_en` is never 1.
  - All bus outputs are 0 whenever `busy`=0.
